// File: rtl/axis_packetizer_pkg.sv
// Shared types for the AXI-Stream packetizer: FSM states and flush causes.
package axis_packetizer_pkg;

  // IDLE: HOLD empty. HELD: HOLD full, tlast still open.
  // FLUSH: HOLD committed as the packet end, waiting for OUT to free up.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HELD  = 2'd1,
    FLUSH = 2'd2
  } pkt_state_e;

  // Why the beat in HOLD is being closed with tlast=1 (NONE = not closing).
  typedef enum logic [1:0] {
    NONE     = 2'd0,
    SRC_LAST = 2'd1,
    MAX      = 2'd2,
    TIMEOUT  = 2'd3
  } flush_cause_e;

endpackage

// File: rtl/axis_packetizer_idle_timer.sv
// Idle timer: counts cycles while enabled, clears on demand, saturates at
// TIMEOUT_CYCLES and flags expiry once the limit is reached.
module idle_timer
  import axis_packetizer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] idle_cnt_q, idle_cnt_d;

  // Clear wins over counting; counting stops at the limit.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (clear) begin
      idle_cnt_d = '0;
    end else if (enable && (idle_cnt_q != LIMIT)) begin
      idle_cnt_d = idle_cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_cnt_q <= '0;
    else        idle_cnt_q <= idle_cnt_d;
  end

  assign expired = (idle_cnt_q == LIMIT);

endmodule

// File: rtl/axis_packetizer.sv
// AXI-Stream packetizer: delays the stream by one beat (HOLD) so tlast can be
// decided for the held beat, then forwards it through a registered output
// stage (OUT). tlast closes a packet on an upstream tlast hint, after
// MAX_BEATS beats, or after TIMEOUT_CYCLES idle cycles.
// Optional feature macro: AXIS_PACKETIZER_STATS_EN adds pkt_count and
// timeout_count outputs.
//
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both 1. A source holds valid and its payload stable until that edge; ready
// may change freely. OUT never changes while m_axis_tvalid=1 and
// m_axis_tready=0.
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BEATS      = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
`ifdef AXIS_PACKETIZER_STATS_EN
  output logic [31:0]             pkt_count,
  output logic [15:0]             timeout_count,
`endif
  output pkt_state_e              dbg_state
);

  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam logic [BW-1:0] MAX_CNT = BW'(MAX_BEATS);

  pkt_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_last_q, hold_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic                  rdy_en_q, rdy_en_d;

  logic                  out_free;
  logic                  s_fire;
  logic                  expired;
  flush_cause_e          cause;

  // Idle cycles since the last accepted beat, counted only while HOLD is open.
  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (s_fire),
    .enable (state_q == HELD),
    .expired(expired)
  );

  // Handshake, flush decision and next-state / datapath update.
  always_comb begin
    out_free      = !out_valid_q || m_axis_tready;
    s_axis_tready = rdy_en_q && ((state_q == IDLE) || ((state_q == HELD) && out_free));
    s_fire        = s_axis_tvalid && s_axis_tready;

    // A new beat beats a coincident timeout, so TIMEOUT needs !s_fire.
    cause = NONE;
    if (state_q == HELD) begin
      if (hold_last_q)                 cause = SRC_LAST;
      else if (beat_cnt_q == MAX_CNT)  cause = MAX;
      else if (expired && !s_fire)     cause = TIMEOUT;
    end

    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    beat_cnt_d  = beat_cnt_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !m_axis_tready;
    rdy_en_d    = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (s_fire) begin
          hold_data_d = s_axis_tdata;
          hold_last_d = s_axis_tlast;
          beat_cnt_d  = beat_cnt_q + BW'(1);
          state_d     = HELD;
        end
      end
      HELD: begin
        if (s_fire) begin
          // s_fire in HELD implies OUT is free: shift HOLD out, refill HOLD.
          out_valid_d = 1'b1;
          out_data_d  = hold_data_q;
          out_last_d  = (cause != NONE);
          hold_data_d = s_axis_tdata;
          hold_last_d = s_axis_tlast;
          beat_cnt_d  = (cause != NONE) ? BW'(1) : beat_cnt_q + BW'(1);
        end else if (cause != NONE) begin
          beat_cnt_d = '0;
          if (out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_data_q;
            out_last_d  = 1'b1;
            state_d     = IDLE;
          end else begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = hold_data_q;
          out_last_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All packetizer state; reset discards any partial packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      beat_cnt_q  <= '0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      beat_cnt_q  <= beat_cnt_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tkeep  = '1;
  assign dbg_state     = state_q;

`ifdef AXIS_PACKETIZER_STATS_EN
  logic [31:0] pkt_count_q;
  logic [15:0] timeout_count_q;
  logic        timeout_hit;

  // A timeout flush is decided in HELD exactly once per flushed packet.
  assign timeout_hit = (state_q == HELD) && (cause == TIMEOUT);

  // Packet counter wraps; timeout counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count_q     <= '0;
      timeout_count_q <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_count_q <= pkt_count_q + 32'd1;
      if (timeout_hit && (timeout_count_q != 16'hFFFF)) timeout_count_q <= timeout_count_q + 16'd1;
    end
  end

  assign pkt_count     = pkt_count_q;
  assign timeout_count = timeout_count_q;
`endif

endmodule
